// File: rtl/uart_tx_driver.sv
// 8N1 UART transmitter fed by a small byte FIFO; optional even parity via UART_TX_PARITY_EN.
// Latency: byte pushed into an empty FIFO at edge N drives the start bit at edge N+1.
// Backpressure: tx_ready drops while the FIFO is full; bytes offered while full are dropped.
module uart_tx_driver #(
    parameter int    DIV        = 563,
    parameter int    FIFO_DEPTH = 4,
    parameter string NAME       = "UART0"
) (
    input  logic        uart_clk,
    input  logic        uart_rst,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_ready,
    output logic        tx_data,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(DIV);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMR_LD  = TW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state;
    logic [TW-1:0]   bit_tmr;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nxt;
    logic            push;
    logic            pop;

    assign push = tx_valid && tx_ready;
    // Pop on the edge a frame starts: from IDLE, or straight out of a finishing STOP.
    assign pop  = (count != '0) &&
                  ((state == IDLE) || ((state == STOP) && (bit_tmr == '0)));
    assign busy = (state != IDLE) || (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge uart_clk) begin
        if (push)
            mem[wr_ptr] <= tx_byte;
    end

    always_ff @(posedge uart_clk or posedge uart_rst) begin
        if (uart_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            tx_ready <= (count_nxt < DEPTH_C);
        end
    end

    always_ff @(posedge uart_clk or posedge uart_rst) begin
        if (uart_rst) begin
            state     <= IDLE;
            bit_tmr   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_data   <= 1'b1;
            frame_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else if (state == IDLE) begin
            tx_data <= 1'b1;
            if (pop) begin
                shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                par_bit   <= ^mem[rd_ptr];
`endif
                tx_data   <= 1'b0;
                bit_tmr   <= TMR_LD;
                state     <= START;
            end
        end else if (bit_tmr != '0) begin
            bit_tmr <= bit_tmr - 1'b1;
        end else begin
            bit_tmr <= TMR_LD;
            case (state)
                START: begin
                    tx_data <= shift_reg[0];
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_data <= par_bit;
                        state   <= PARITY;
`else
                        tx_data <= 1'b1;
                        state   <= STOP;
`endif
                    end else begin
                        tx_data   <= shift_reg[1];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    tx_data <= 1'b1;
                    state   <= STOP;
                end
`endif
                STOP: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        par_bit   <= ^mem[rd_ptr];
`endif
                        tx_data   <= 1'b0;
                        state     <= START;
                    end else begin
                        tx_data <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    tx_data <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge uart_clk) begin
        if (!uart_rst && pop)
            $display("[%s]: TX 0x%02h", NAME, mem[rd_ptr]);
        if (!uart_rst && tx_valid && !tx_ready)
            $display("[%s] overflow", NAME);
    end
`endif
endmodule

// File: tb/tb_uart_tx_driver.sv
// Bench for uart_tx_driver: per-cycle comparison against a frame-schedule reference model.
module tb_uart_tx_driver;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic        uart_clk = 1'b0;
    logic        uart_rst = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_byte  = 8'h00;
    logic        tx_ready;
    logic        tx_data;
    logic        busy;
    logic [15:0] frame_cnt;

    int cmp_n  = 0;
    int fail_n = 0;
    int cyc    = 0;

    // Model: accept edge, start edge and byte of every frame since the last reset.
    int         a_e[$];
    int         s_e[$];
    logic [7:0] f_dat[$];

    uart_tx_driver #(.DIV(DIV), .FIFO_DEPTH(DEPTH), .NAME("UART0")) dut (
        .uart_clk  (uart_clk),
        .uart_rst  (uart_rst),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 uart_clk = ~uart_clk;
    always @(posedge uart_clk) cyc++;

    function automatic logic exp_line(int t);
        for (int k = 0; k < s_e.size(); k++) begin
            if (t >= s_e[k] && t < s_e[k] + FL) begin
                int i;
                logic [7:0] d;
                i = (t - s_e[k]) / DIV;
                d = f_dat[k];
                if (i == 0) return 1'b0;
                if (i <= 8) return d[i-1];
                if (i == NB - 1) return 1'b1;
                return ^d;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(int t);
        for (int k = 0; k < a_e.size(); k++)
            if (t >= a_e[k] && t < s_e[k] + FL) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_rdy(int t);
        int occ;
        occ = 0;
        for (int k = 0; k < a_e.size(); k++) begin
            if (a_e[k] <= t) occ++;
            if (s_e[k] <= t) occ--;
        end
        return occ < DEPTH;
    endfunction

    function automatic logic [15:0] exp_fc(int t);
        int n;
        n = 0;
        for (int k = 0; k < s_e.size(); k++)
            if (s_e[k] + FL <= t) n++;
        return 16'(n);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        cmp_n++;
        assert (obs === exp_v) else begin
            fail_n++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_all();
        chk("tx_data",   {15'd0, tx_data},  {15'd0, exp_line(cyc)});
        chk("busy",      {15'd0, busy},     {15'd0, exp_busy(cyc)});
        chk("tx_ready",  {15'd0, tx_ready}, {15'd0, exp_rdy(cyc)});
        chk("frame_cnt", frame_cnt,         exp_fc(cyc));
    endtask

    // One clock: optionally offer a byte, then check every output against the model.
    task automatic step(input bit do_push, input logic [7:0] b);
        bit acc;
        acc      = do_push && exp_rdy(cyc);
        tx_valid = do_push;
        tx_byte  = b;
        @(posedge uart_clk);
        #1;
        tx_valid = 1'b0;
        if (acc) begin
            int st;
            st = cyc + 1;
            if (s_e.size() > 0 && s_e[s_e.size()-1] + FL > st)
                st = s_e[s_e.size()-1] + FL;
            a_e.push_back(cyc);
            s_e.push_back(st);
            f_dat.push_back(b);
        end
        check_all();
    endtask

    task automatic drain();
        int last_end;
        last_end = (s_e.size() > 0) ? s_e[s_e.size()-1] + FL : cyc;
        for (int i = 0; i < 4000 && cyc < last_end + 2; i++)
            step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        uart_rst = 1'b1;
        #1;
        a_e.delete();
        s_e.delete();
        f_dat.delete();
        chk("rst_tx_data",   {15'd0, tx_data},  16'd1);
        chk("rst_tx_ready",  {15'd0, tx_ready}, 16'd0);
        chk("rst_busy",      {15'd0, busy},     16'd0);
        chk("rst_frame_cnt", frame_cnt,         16'd0);
        @(posedge uart_clk);
        #1;
        chk("rst_hold_ready", {15'd0, tx_ready}, 16'd0);
        uart_rst = 1'b0;
        #1;
        chk("rel_ready_pre_edge", {15'd0, tx_ready}, 16'd0);
        step(1'b0, 8'h00);
    endtask

    initial begin
        int s0;
        #2;
        do_reset();

        // Single byte with the alternating pattern.
        step(1'b1, 8'h55);
        drain();

        // Back-to-back contiguous frames.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h00);
        drain();

        // Parity-sensitive bytes (odd and even weight).
        step(1'b1, 8'h07);
        step(1'b1, 8'h03);
        drain();

        // Overflow: six pushes on consecutive cycles from idle.
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'($urandom));
        drain();

        // Random traffic, pushes landing mid-frame and while full.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 60; i++)
                step($urandom_range(0, 9) < 3, 8'($urandom));
            if (r % 2 == 1) drain();
        end
        drain();

        // Reset during DATA bit 3 of 0x0F with a second byte still queued.
        step(1'b1, 8'h0F);
        step(1'b1, 8'h22);
        s0 = s_e[s_e.size()-2];
        for (int i = 0; i < 200 && cyc < s0 + 4 * DIV + 1; i++)
            step(1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < 3 * DIV; i++)
            step(1'b0, 8'h00);
        step(1'b1, 8'h81);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end
endmodule
